// File: rtl/fp_add_pkg.sv
// Shared types and constants for the FP add scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package fp_add_pkg;

    typedef logic [31:0] fp32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int              FP_EXP_W    = 8;
    localparam int              FP_MAN_W    = 23;
    localparam logic [30:0]     FP_ZERO_MAG = 31'b0;

endpackage

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// Round-robin arbiter: lowest requester index at or after ptr wins, wrapping at N-1.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; grant follows req/ptr.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);
    // Scan requesters starting at ptr; first hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!any && req[(int'(ptr) + off) % N]) begin
                any                          = 1'b1;
                gnt[(int'(ptr) + off) % N]   = 1'b1;
                idx                          = ID_W'((int'(ptr) + off) % N);
            end
        end
    end

endmodule

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
module fp_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic        sa, sb, s_big, s_small;
    logic [7:0]  ea, eb, eff_a, eff_b, e_big, e_small, d;
    logic [23:0] ma, mb, m_big, m_small;
    logic [4:0]  dcap, lz, shamt;
    logic [55:0] wide;
    logic [26:0] al_small, big27, n;
    logic [27:0] s;
    logic [9:0]  e_n, e_r;
    logic [24:0] mant_r;
    logic        rnd, lz_found;
    logic        a_nan, b_nan, a_inf, b_inf;

    // Align, add/subtract, normalise and round in one combinational pass.
    always_comb begin
        sa    = a[31];
        sb    = b[31];
        ea    = a[30:23];
        eb    = b[30:23];
        ma    = {|ea, a[22:0]};
        mb    = {|eb, b[22:0]};
        // Denormals share exponent 1 with a zero hidden bit.
        eff_a = (ea == 8'd0) ? 8'd1 : ea;
        eff_b = (eb == 8'd0) ? 8'd1 : eb;
        a_nan = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (eb == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (eb == 8'hFF) && (b[22:0] == 23'd0);

        if ({eff_a, ma} >= {eff_b, mb}) begin
            s_big = sa; e_big = eff_a; m_big = ma;
            s_small = sb; e_small = eff_b; m_small = mb;
        end else begin
            s_big = sb; e_big = eff_b; m_big = mb;
            s_small = sa; e_small = eff_a; m_small = ma;
        end

        d        = e_big - e_small;
        dcap     = (d > 8'd31) ? 5'd31 : d[4:0];
        wide     = {m_small, 32'b0} >> dcap;
        // 24 mantissa bits + guard + round, then a sticky bit for everything below.
        al_small = {wide[55:30], |wide[29:0]};
        big27    = {m_big, 3'b000};

        if (s_big == s_small) s = {1'b0, big27} + {1'b0, al_small};
        else                  s = {1'b0, big27} - {1'b0, al_small};

        lz       = 5'd0;
        lz_found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!lz_found && s[i]) begin
                lz       = 5'(26 - i);
                lz_found = 1'b1;
            end
        end

        shamt = 5'd0;
        if (s[27]) begin
            n   = {s[27:2], s[1] | s[0]};
            e_n = {2'b0, e_big} + 10'd1;
        end else begin
            // Never normalise below exponent 1; the remainder becomes a denormal.
            if ({3'b0, lz} > (e_big - 8'd1)) shamt = 5'(e_big - 8'd1);
            else                             shamt = lz;
            n   = s[26:0] << shamt;
            e_n = {2'b0, e_big} - {5'b0, shamt};
            if (!n[26]) e_n = 10'd0;
        end

        rnd    = n[2] & (n[1] | n[0] | n[3]);
        mant_r = {1'b0, n[26:3]} + {24'b0, rnd};
        e_r    = e_n;
        if (mant_r[24]) begin
            mant_r = {1'b0, mant_r[24:1]};
            e_r    = e_n + 10'd1;
        end else if ((e_n == 10'd0) && mant_r[23]) begin
            e_r = 10'd1;
        end

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) sum = 32'h7FC0_0000;
        else if (a_inf)                                       sum = a;
        else if (b_inf)                                       sum = b;
        else if (s == 28'd0)                                  sum = {sa & sb, 31'b0};
        else if (e_r >= 10'd255)                              sum = {s_big, 8'hFF, 23'b0};
        else                                                  sum = {s_big, e_r[7:0], mant_r[22:0]};
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one combinational fp_adder among NUM_REQ requesters (round robin, tagged response).
// Latency: accept at edge t, result registered at t+1, handshake earliest at t+2; one op in flight.
// Backpressure: rsp_ready=0 holds RESP indefinitely; req_ready stays 0 until IDLE. Option: FP_ZERO_BYPASS_EN.
module fp_add_scheduler
    import fp_add_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_sum,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);
    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    fp32_t             a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [ID_W-1:0]   id_q, id_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    fp32_t              add_sum, exec_sum;

    rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    fp_adder u_add (
        .a   (a_q),
        .b   (b_q),
        .sum (add_sum)
    );

    // Select the value captured in EXEC: adder output, or zero-operand shortcut when enabled.
    always_comb begin
`ifdef FP_ZERO_BYPASS_EN
        if ((a_q[30:0] == FP_ZERO_MAG) && (b_q[30:0] == FP_ZERO_MAG)) exec_sum = {a_q[31] & b_q[31], FP_ZERO_MAG};
        else if (a_q[30:0] == FP_ZERO_MAG)                            exec_sum = b_q;
        else if (b_q[30:0] == FP_ZERO_MAG)                            exec_sum = a_q;
        else                                                          exec_sum = add_sum;
`else
        exec_sum = add_sum;
`endif
    end

    // Next-state and grant logic; only IDLE may accept.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        sum_d     = sum_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (gnt_any) begin
                    a_d      = req_a[32*gnt_idx +: 32];
                    b_d      = req_b[32*gnt_idx +: 32];
                    id_d     = gnt_idx;
                    rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                sum_d   = exec_sum;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            sum_q    <= sum_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler: reset, single op, round robin, backpressure,
// reset mid-op, pointer wrap and zero-operand handling. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_fp_add_scheduler;
    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_sum;
    logic [1:0]   rsp_id;
    logic         busy;

    int checks;
    int failures;

    fp_add_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        #2;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_sum !== 32'h0) begin failures++; $display("FAIL rst_rsp_sum: got %h expected 00000000", rsp_sum); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL rst_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single;
        @(negedge clk);
        rsp_ready = 1'b1; req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h3F80_0000; req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL t1_grant: got %b expected 0001", req_ready); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL t1_exec: busy=%b rsp_valid=%b expected busy=1 rsp_valid=0", busy, rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL t1_exec_ready: got %b expected 0000", req_ready); end
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL t1_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_sum !== 32'h4000_0000) begin failures++; $display("FAIL t1_sum: got %h expected 40000000", rsp_sum); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL t1_id: got %0d expected 0", rsp_id); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL t1_done: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin;
        int          order [5];
        logic [31:0] exp_sum [4];
        logic [3:0]  exp_gnt;
        order   = '{0, 1, 2, 3, 0};
        exp_sum = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h3FC0_0000};
        // Restart with the pointer at requester 0.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_a[32*i +: 32] = 32'h3F80_0000;
        req_b[31:0]  = 32'h3F80_0000;
        req_b[63:32] = 32'h4000_0000;
        req_b[95:64] = 32'h4040_0000;
        req_b[127:96] = 32'h3F00_0000;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_gnt = 4'b0001 << order[k];
            checks++; if (req_ready !== exp_gnt) begin failures++; $display("FAIL t2_grant[%0d]: got %b expected %b", k, req_ready, exp_gnt); end
            @(negedge clk);
            #1;
            checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL t2_exec[%0d]: ready=%b busy=%b expected 0000 1", k, req_ready, busy); end
            req_valid[order[k]] = 1'b0;
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(order[k])) begin failures++; $display("FAIL t2_rsp[%0d]: valid=%b id=%0d expected 1 %0d", k, rsp_valid, rsp_id, order[k]); end
            checks++; if (rsp_sum !== exp_sum[order[k]]) begin failures++; $display("FAIL t2_sum[%0d]: got %h expected %h", k, rsp_sum, exp_sum[order[k]]); end
            req_valid[order[k]] = 1'b1;
            @(negedge clk);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_a[95:64] = 32'h3FC0_0000; req_b[95:64] = 32'h3FC0_0000;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL t3_grant: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL t3_exec_ready: got %b expected 0000", req_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL t3_hold_valid[%0d]: valid=%b busy=%b expected 1 1", c, rsp_valid, busy); end
            checks++; if (rsp_sum !== 32'h4040_0000 || rsp_id !== 2'd2) begin failures++; $display("FAIL t3_hold_data[%0d]: sum=%h id=%0d expected 40400000 2", c, rsp_sum, rsp_id); end
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL t3_hold_ready[%0d]: got %b expected 0000", c, req_ready); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL t3_release: valid=%b busy=%b expected 0 0", rsp_valid, busy); end
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL t3_next_grant: got %b expected 0001", req_ready); end
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid_op;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_a[63:32] = 32'h3F80_0000; req_b[63:32] = 32'h3F80_0000;
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = 4'b0000;
        checks++; if (busy !== 1'b1 || rsp_id !== 2'd1) begin failures++; $display("FAIL t4_exec: busy=%b id=%0d expected 1 1", busy, rsp_id); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL t4_abort_ctl: busy=%b valid=%b ready=%b expected 0 0 0000", busy, rsp_valid, req_ready); end
        checks++; if (rsp_sum !== 32'h0 || rsp_id !== 2'd0) begin failures++; $display("FAIL t4_abort_data: sum=%h id=%0d expected 00000000 0", rsp_sum, rsp_id); end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL t4_quiet[%0d]: valid=%b busy=%b expected 0 0", c, rsp_valid, busy); end
        end
    endtask

    task automatic test_pointer_wrap;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_a[127:96] = 32'h3F80_0000; req_b[127:96] = 32'h3F00_0000;
        req_a[63:32]  = 32'h3F80_0000; req_b[63:32]  = 32'h4000_0000;
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL t5_grant3: got %b expected 1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b1010;
        @(negedge clk);
        checks++; if (rsp_id !== 2'd3 || rsp_sum !== 32'h3FC0_0000) begin failures++; $display("FAIL t5_rsp3: id=%0d sum=%h expected 3 3fc00000", rsp_id, rsp_sum); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL t5_wrap_grant: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b1000;
        @(negedge clk);
        checks++; if (rsp_id !== 2'd1 || rsp_sum !== 32'h4040_0000) begin failures++; $display("FAIL t5_rsp1: id=%0d sum=%h expected 1 40400000", rsp_id, rsp_sum); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL t5_grant3_again: got %b expected 1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin failures++; $display("FAIL t5_rsp3_again: valid=%b id=%0d expected 1 3", rsp_valid, rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_zero_bypass;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_a[31:0] = 32'h0000_0000; req_b[31:0] = 32'hBF80_0000;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL t6_grant: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL t6_exec_valid: got %b expected 0", rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL t6_rsp_valid: got %b expected 1", rsp_valid); end
`ifdef FP_ZERO_BYPASS_EN
        checks++; if (rsp_sum !== 32'hBF80_0000) begin failures++; $display("FAIL t6_sum: got %h expected bf800000", rsp_sum); end
`endif
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL t6_done: got %b expected 0", rsp_valid); end
`ifdef FP_ZERO_BYPASS_EN
        req_a[31:0] = 32'h8000_0000; req_b[31:0] = 32'h8000_0000;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'h8000_0000) begin failures++; $display("FAIL t6_neg_zero: valid=%b sum=%h expected 1 80000000", rsp_valid, rsp_sum); end
        @(negedge clk);
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_pointer_wrap();
        test_zero_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
